// File: rtl/adder_tree_acc_pkg.sv
// Shared helpers for the adder tree: tree geometry, tap masking and
// accumulator saturation.
package adder_pkg;

   localparam int MAX_W = 64;

   function automatic int tree_depth(input int taps);
      return $clog2(taps);
   endfunction

   // Element count at tree level k; an odd leftover passes through.
   function automatic int lvl_cnt(input int taps, input int k);
      int n = taps;
      for (int j = 0; j < k; j++) n = (n + 1) / 2;
      return n;
   endfunction

   // Bit offset of level k inside a flat per-channel vector that holds all levels.
   function automatic int lvl_off(input int taps, input int in_w, input int k);
      int o = 0;
      for (int j = 0; j < k; j++) o += lvl_cnt(taps, j) * (in_w + j);
      return o;
   endfunction

   function automatic logic signed [MAX_W-1:0] sat_add(input logic signed [MAX_W-1:0] v,
                                                       input int w);
      logic signed [MAX_W-1:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic [MAX_W-1:0] tap_mask(input int n, input int taps);
      logic [MAX_W-1:0] m = '0;
      for (int i = 0; i < MAX_W; i++)
         if (i < n && i < taps) m[i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/adder_tree_acc_if.sv
// Beat-in / psum-out handshake bundle of the adder tree accumulator.
interface adder_tree_acc_if #(
   parameter int N_CH  = 8,
   parameter int TAPS  = 9,
   parameter int IN_W  = 16,
   parameter int ACC_W = 24
);
   logic                           in_valid, in_ready, in_first, in_last;
   logic [N_CH*TAPS*IN_W-1:0]      in_data;
   logic [$clog2(TAPS+1)-1:0]      in_taps;
   logic                           out_valid, out_ready;
   logic [N_CH*ACC_W-1:0]          out_data;
   logic [N_CH-1:0]                out_sat;
   logic                           err_seq;

   modport master (
      output in_valid, in_data, in_taps, in_first, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sat, err_seq
   );

   modport slave (
      input  in_valid, in_data, in_taps, in_first, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sat, err_seq
   );
endinterface

// File: rtl/adder_tree_acc_level.sv
// One registered level of pairwise signed adds; an odd last element is
// sign-extended and passed through.
module adder_tree_level #(
   parameter  int N_IN  = 9,
   parameter  int W     = 16,
   localparam int N_OUT = (N_IN + 1) / 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_IN*W-1:0]      d,
   output logic [N_OUT*(W+1)-1:0] q
);
   logic [N_OUT*(W+1)-1:0] nxt;

   for (genvar i = 0; i < N_OUT; i++) begin : g_out
      logic signed [W:0] a, b;
      assign a = {d[(2*i+1)*W-1], d[2*i*W +: W]};
      if (2*i + 1 < N_IN) begin : g_pair
         assign b = {d[(2*i+2)*W-1], d[(2*i+1)*W +: W]};
      end else begin : g_pass
         assign b = '0;
      end
      assign nxt[i*(W+1) +: W+1] = a + b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (en) q <= nxt;
   end
endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined per-channel adder tree with group accumulation, saturation and
// valid/ready flow control between the multiplier array and the psum buffer.
module adder_tree_acc
   import adder_pkg::*;
#(
   parameter int N_CH  = 8,
   parameter int TAPS  = 9,
   parameter int IN_W  = 16,
   parameter int ACC_W = 24
) (
   input logic             clk,
   input logic             rst,
   adder_tree_acc_if.slave bus
);
   localparam int D   = tree_depth(TAPS);
   localparam int SW  = IN_W + D;
   localparam int TOT = lvl_off(TAPS, IN_W, D) + SW;
   localparam int DW  = N_CH * TAPS * IN_W;

   logic                       en, accept, grp_open, err_q, out_valid;
   logic [D:0]                 vld_pipe, first_pipe, last_pipe;
   logic [TAPS-1:0]            mask;
   logic [DW-1:0]              masked, s0_data;
   logic [N_CH-1:0][SW-1:0]    sum;
   logic [N_CH-1:0][ACC_W-1:0] acc, acc_nxt, out_data;
   logic [N_CH-1:0]            gsat, gsat_nxt, out_sat;

   // The output register is the only stall point; all stages advance together.
   assign en     = !out_valid || bus.out_ready;
   assign accept = bus.in_valid && en;

   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_sat   = out_sat;
   assign bus.err_seq   = err_q;

   assign mask = TAPS'(tap_mask(int'(bus.in_taps), TAPS));

   always_comb begin
      masked = bus.in_data;
      for (int c = 0; c < N_CH; c++)
         for (int t = 0; t < TAPS; t++)
            if (!mask[t]) masked[(c*TAPS+t)*IN_W +: IN_W] = '0;
   end

   // A continuation beat with no open group is promoted to a group start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe   <= '0;
         first_pipe <= '0;
         last_pipe  <= '0;
         s0_data    <= '0;
         grp_open   <= 1'b0;
         err_q      <= 1'b0;
      end else if (en) begin
         vld_pipe[0]   <= accept;
         first_pipe[0] <= bus.in_first || !grp_open;
         last_pipe[0]  <= bus.in_last;
         for (int k = 1; k <= D; k++) begin
            vld_pipe[k]   <= vld_pipe[k-1];
            first_pipe[k] <= first_pipe[k-1];
            last_pipe[k]  <= last_pipe[k-1];
         end
         s0_data <= masked;
         if (accept) begin
            grp_open <= !bus.in_last;
            if (!bus.in_first && !grp_open) err_q <= 1'b1;
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [TOT-1:0] tv;  // all tree levels of this channel, level 0 at the bottom
      assign tv[0 +: TAPS*IN_W] = s0_data[c*TAPS*IN_W +: TAPS*IN_W];
      for (genvar k = 0; k < D; k++) begin : g_lvl
         localparam int NI = lvl_cnt(TAPS, k);
         localparam int NO = lvl_cnt(TAPS, k + 1);
         adder_tree_level #(.N_IN(NI), .W(IN_W + k)) u_lvl (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (tv[lvl_off(TAPS, IN_W, k) +: NI*(IN_W+k)]),
            .q   (tv[lvl_off(TAPS, IN_W, k+1) +: NO*(IN_W+k+1)])
         );
      end
      assign sum[c] = tv[lvl_off(TAPS, IN_W, D) +: SW];
   end

   always_comb begin
      logic signed [ACC_W:0] s_ext, ext;
      s_ext    = '0;
      ext      = '0;
      acc_nxt  = '0;
      gsat_nxt = '0;
      for (int c = 0; c < N_CH; c++) begin
         s_ext = {{(ACC_W+1-SW){sum[c][SW-1]}}, sum[c]};
         ext   = first_pipe[D] ? s_ext : {acc[c][ACC_W-1], acc[c]} + s_ext;
         acc_nxt[c]  = ACC_W'(sat_add(MAX_W'(ext), ACC_W));
         gsat_nxt[c] = (first_pipe[D] ? 1'b0 : gsat[c]) | (ext[ACC_W] ^ ext[ACC_W-1]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         gsat      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
      end else begin
         if (en && vld_pipe[D]) begin
            acc  <= acc_nxt;
            gsat <= last_pipe[D] ? '0 : gsat_nxt;
            if (last_pipe[D]) begin
               out_data <= acc_nxt;
               out_sat  <= gsat_nxt;
            end
         end
         if (en && vld_pipe[D] && last_pipe[D]) out_valid <= 1'b1;
         else if (bus.out_ready)               out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc with a plain-arithmetic group model and
// an in-order scoreboard checked on every output handshake.
module tb_adder_tree_acc;
   localparam int N_CH = 2, TAPS = 9, IN_W = 8, ACC_W = 16;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  sat;
   } want_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   adder_tree_acc_if #(.N_CH(N_CH), .TAPS(TAPS), .IN_W(IN_W), .ACC_W(ACC_W)) bus ();

   adder_tree_acc #(.N_CH(N_CH), .TAPS(TAPS), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   want_t    exp_q[$];
   int       prod[N_CH][TAPS];
   int       m_acc[N_CH];
   bit [1:0] m_sat;
   bit       m_open, m_err;
   int       errors = 0, checks = 0, ov_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic model_reset();
      m_open = 1'b0;
      m_err  = 1'b0;
      m_sat  = '0;
      for (int c = 0; c < N_CH; c++) m_acc[c] = 0;
      exp_q.delete();
   endtask

   // Group semantics straight from the block description, in integers.
   task automatic model_accept(input int taps, input bit f, input bit l);
      bit    ef;
      int    s, v;
      want_t w;
      ef = f || !m_open;
      if (!f && !m_open) m_err = 1'b1;
      m_open = !l;
      for (int c = 0; c < N_CH; c++) begin
         s = 0;
         for (int t = 0; t < TAPS; t++) if (t < taps) s += prod[c][t];
         if (ef) m_sat[c] = 1'b0;
         v = ef ? s : m_acc[c] + s;
         if (v > 32767)       begin v = 32767;  m_sat[c] = 1'b1; end
         else if (v < -32768) begin v = -32768; m_sat[c] = 1'b1; end
         m_acc[c] = v;
      end
      if (l) begin
         w.data = {16'(m_acc[1]), 16'(m_acc[0])};
         w.sat  = m_sat;
         exp_q.push_back(w);
         m_sat = '0;
      end
   endtask

   task automatic fill(input int c, input int v0, input int vr);
      prod[c][0] = v0;
      for (int t = 1; t < TAPS; t++) prod[c][t] = vr;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Called 1 time unit after a rising edge; returns at the same phase.
   task automatic send(input int taps, input bit f, input bit l);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_taps  = 4'(taps);
      bus.in_first = f;
      bus.in_last  = l;
      for (int c = 0; c < N_CH; c++)
         for (int t = 0; t < TAPS; t++)
            bus.in_data[(c*TAPS+t)*IN_W +: IN_W] = 8'(prod[c][t]);
      #1;
      while (!bus.in_ready && n < 100) begin @(posedge clk); #2; n++; end
      if (!bus.in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stuck at %0b, expected 1", bus.in_ready);
         bus.in_valid = 1'b0;
         @(posedge clk); #1;
      end else begin
         @(posedge clk);
         model_accept(taps, f, l);
         #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic wait_out(input string name);
      int n = 0;
      while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.out_valid) begin
         checks++; errors++;
         $display("FAIL %s: out_valid never rose, expected 1", name);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   always @(negedge clk) begin : p_cmp
      want_t w;
      if (!rst && bus.out_valid && bus.out_ready) begin
         ov_cnt++;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got %0h, expected no output", bus.out_data);
         end else begin
            w = exp_q.pop_front();
            chk("sb_data", bus.out_data, w.data);
            chk("sb_sat", 32'(bus.out_sat), 32'(w.sat));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t, expected earlier finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, base;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_taps   = '0;
      bus.in_first  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      model_reset();
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_sat", 32'(bus.out_sat), 0);
      chk("rst_err_seq", 32'(bus.err_seq), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);

      // all ones, full taps: latency and value
      fill(0, 1, 1); fill(1, 1, 1);
      send(9, 1, 1);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("t1_latency", 32'(lat), 5);
      chk("t1_data", bus.out_data, 32'h0009_0009);
      chk("t1_sat", 32'(bus.out_sat), 0);

      // single active tap, masked taps carry garbage
      fill(0, -3, 100); fill(1, -3, 100);
      send(1, 1, 1);
      wait_out("t2_wait");
      chk("t2_data", bus.out_data, 32'hFFFD_FFFD);

      // three-beat group 10 + 20 + 30
      tick(2);
      base = ov_cnt;
      fill(0, 2, 1); fill(1, 10, 0); send(9, 1, 0);
      fill(0, 4, 2); fill(1, 20, 0); send(9, 0, 0);
      fill(0, 6, 3); fill(1, 30, 0); send(9, 0, 1);
      wait_out("t3_wait");
      chk("t3_data", bus.out_data, 32'h003C_003C);
      tick(3);
      chk("t3_pulses", 32'(ov_cnt - base), 1);

      // saturation over 29 beats of 9*127, then a clean group
      fill(0, 127, 127); fill(1, 127, 127);
      for (int i = 0; i < 29; i++) send(9, i == 0, i == 28);
      wait_out("t4_wait");
      chk("t4_data", bus.out_data, 32'h7FFF_7FFF);
      chk("t4_sat", 32'(bus.out_sat), 3);
      fill(0, 1, 1); fill(1, 1, 1);
      send(9, 1, 1);
      wait_out("t4b_wait");
      chk("t4b_data", bus.out_data, 32'h0009_0009);
      chk("t4b_sat", 32'(bus.out_sat), 0);
      tick(2);

      // back-to-back single-beat groups with a 3-cycle downstream stall
      fork
         begin
            for (int k = 1; k <= 8; k++) begin
               fill(0, k, 0); fill(1, 2*k, 0);
               send(9, 1, 1);
            end
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            #1;
            chk("t5_stall_rdy", 32'(bus.in_ready), 0);
            chk("t5_stall_vld", 32'(bus.out_valid), 1);
            repeat (2) begin
               @(posedge clk); #2;
               chk("t5_hold_rdy", 32'(bus.in_ready), 0);
               chk("t5_hold_vld", 32'(bus.out_valid), 1);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
         end
      join
      tick(20);
      chk("t5_drain", 32'(exp_q.size()), 0);

      // reset mid-group, then an orphan continuation beat
      fill(0, 5, 0); fill(1, 5, 0);
      send(9, 1, 0);
      tick(1);
      do_reset();
      chk("t6_rst_err", 32'(bus.err_seq), 0);
      chk("t6_rst_vld", 32'(bus.out_valid), 0);
      chk("t6_rst_data", bus.out_data, 0);
      fill(0, 7, 0); fill(1, 7, 0);
      send(9, 0, 1);
      wait_out("t6_wait");
      chk("t6_data", bus.out_data, 32'h0007_0007);
      chk("t6_err", 32'(bus.err_seq), 1);
      chk("t6_err_model", 32'(bus.err_seq), 32'(m_err));
      fill(0, 1, 1); fill(1, 1, 1);
      send(9, 1, 1);
      wait_out("t6b_wait");
      chk("t6b_data", bus.out_data, 32'h0009_0009);
      chk("t6b_err_sticky", 32'(bus.err_seq), 1);
      tick(3);
      do_reset();
      chk("t6_err_cleared", 32'(bus.err_seq), 0);

      tick(5);
      chk("final_drain", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
